// File: rtl/core_csr_pkg.sv
// Shared constants, sequencer states and mstatus update helpers for the
// CSR trap/MRET sequencer.
package core_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MBADADDR = 12'h343;

  localparam int MST_MIE    = 3;
  localparam int MST_MPIE   = 7;
  localparam int MST_MPP_LO = 11;
  localparam int MST_MPP_HI = 12;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_T_RD_MST    = 4'd1,
    ST_T_WR_MEPC   = 4'd2,
    ST_T_WR_MCAUSE = 4'd3,
    ST_T_WR_MTVAL  = 4'd4,
    ST_T_WR_MST    = 4'd5,
    ST_T_RD_TVEC   = 4'd6,
    ST_M_RD_MST    = 4'd7,
    ST_M_WR_MST    = 4'd8,
    ST_M_RD_MEPC   = 4'd9,
    ST_REDIRECT    = 4'd10
  } seq_state_e;

  // Read-modify-write keeps every mstatus field the sequencer does not own.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] old_val,
                                               input logic        mie,
                                               input logic [1:0]  mpp);
    logic [31:0] v;
    v                        = old_val;
    v[MST_MPP_HI:MST_MPP_LO] = mpp;
    v[MST_MPIE]              = mie;
    v[MST_MIE]               = 1'b0;
    return v;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] old_val,
                                               input logic        mpie);
    logic [31:0] v;
    v                        = old_val;
    v[MST_MPP_HI:MST_MPP_LO] = 2'b00;
    v[MST_MPIE]              = 1'b1;
    v[MST_MIE]               = mpie;
    return v;
  endfunction

endpackage

// File: rtl/core_tvec_target.sv
// Trap target from mtvec and mcause: direct base, or base + 4*cause for
// vectored interrupts when enabled.
module core_tvec_target #(
  parameter bit TVEC_VECTORED_EN = 1'b1
) (
  input  logic [31:0] mtvec,
  input  logic [31:0] cause,
  output logic [31:0] target
);

  logic [31:0] base_s;

  // Modes 2'b10/2'b11 fall through to direct; the add wraps at 32 bits.
  always_comb begin
    base_s = {mtvec[31:2], 2'b00};
    if (TVEC_VECTORED_EN && (mtvec[1:0] == 2'b01) && cause[31]) begin
      target = base_s + {25'd0, cause[4:0], 2'b00};
    end else begin
      target = base_s;
    end
  end

endmodule

// File: rtl/core_csr_trap_ctrl.sv
// Arbiter/sequencer for the CSR file's single port: instruction accesses
// pass through in IDLE, trap entry and MRET run as multi-cycle sequences.
module core_csr_trap_ctrl
  import core_csr_pkg::*;
#(
  parameter bit         TVEC_VECTORED_EN = 1'b1,
  parameter logic [1:0] TRAP_MPP         = 2'b11
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INST_CSR_REQ,
  input  logic [11:0] INST_CSR_ADDR,
  input  logic        INST_CSR_WE,
  input  logic [31:0] INST_CSR_WDATA,
  output logic        INST_CSR_ACK,
  output logic [31:0] INST_CSR_RDATA,
  input  logic        TRAP_REQ,
  input  logic [31:0] TRAP_CAUSE,
  input  logic [31:0] TRAP_PC,
  input  logic [31:0] TRAP_TVAL,
  input  logic        MRET_REQ,
  output logic        TRAP_ACK,
  output logic        REDIRECT_VALID,
  output logic [31:0] REDIRECT_PC,
  output logic        BUSY,
  output logic [11:0] CSR_ADDR,
  output logic [31:0] CSR_WDATA,
  output logic        CSR_WE,
  input  logic [31:0] CSR_RDATA
);

  seq_state_e  state_r, next_state_s;
  logic [31:0] cause_r, pc_r, tval_r, redirect_pc_r, tvec_target_s;
  logic        cap_bit_r, redirect_valid_r;
  logic        idle_s, trap_grant_s, mret_grant_s, inst_grant_s;

  // Grants are masked during reset so every output reads zero at once.
  assign idle_s       = (state_r == ST_IDLE) && !RST;
  assign trap_grant_s = idle_s && TRAP_REQ;
  assign mret_grant_s = idle_s && !TRAP_REQ && MRET_REQ;
  assign inst_grant_s = idle_s && !TRAP_REQ && !MRET_REQ && INST_CSR_REQ;

  assign TRAP_ACK       = trap_grant_s || mret_grant_s;
  assign INST_CSR_ACK   = inst_grant_s;
  assign INST_CSR_RDATA = inst_grant_s ? CSR_RDATA : 32'h0;
  assign BUSY           = (state_r != ST_IDLE);
  assign REDIRECT_VALID = redirect_valid_r;
  assign REDIRECT_PC    = redirect_pc_r;

  core_tvec_target #(
    .TVEC_VECTORED_EN(TVEC_VECTORED_EN)
  ) u_tvec (
    .mtvec (CSR_RDATA),
    .cause (cause_r),
    .target(tvec_target_s)
  );

  // Next state, CSR address and write strobe; never reads CSR_RDATA.
  always_comb begin
    next_state_s = state_r;
    CSR_ADDR     = 12'h000;
    CSR_WE       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (trap_grant_s) begin
          next_state_s = ST_T_RD_MST;
        end else if (mret_grant_s) begin
          next_state_s = ST_M_RD_MST;
        end else if (inst_grant_s) begin
          CSR_ADDR = INST_CSR_ADDR;
          CSR_WE   = INST_CSR_WE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_T_RD_MST:    begin CSR_ADDR = CSR_MSTATUS;  next_state_s = ST_T_WR_MEPC;   end
      ST_T_WR_MEPC:   begin CSR_ADDR = CSR_MEPC;     CSR_WE = 1'b1; next_state_s = ST_T_WR_MCAUSE; end
      ST_T_WR_MCAUSE: begin CSR_ADDR = CSR_MCAUSE;   CSR_WE = 1'b1; next_state_s = ST_T_WR_MTVAL;  end
      ST_T_WR_MTVAL:  begin CSR_ADDR = CSR_MBADADDR; CSR_WE = 1'b1; next_state_s = ST_T_WR_MST;    end
      ST_T_WR_MST:    begin CSR_ADDR = CSR_MSTATUS;  CSR_WE = 1'b1; next_state_s = ST_T_RD_TVEC;   end
      ST_T_RD_TVEC:   begin CSR_ADDR = CSR_MTVEC;    next_state_s = ST_REDIRECT;    end
      ST_M_RD_MST:    begin CSR_ADDR = CSR_MSTATUS;  next_state_s = ST_M_WR_MST;    end
      ST_M_WR_MST:    begin CSR_ADDR = CSR_MSTATUS;  CSR_WE = 1'b1; next_state_s = ST_M_RD_MEPC; end
      ST_M_RD_MEPC:   begin CSR_ADDR = CSR_MEPC;     next_state_s = ST_REDIRECT;    end
      ST_REDIRECT:    begin next_state_s = ST_IDLE; end
      default:        begin next_state_s = ST_IDLE; end
    endcase
  end

  // Write data kept apart from the address path so RDATA feeds only data.
  always_comb begin
    CSR_WDATA = 32'h0;
    case (state_r)
      ST_IDLE:        CSR_WDATA = inst_grant_s ? INST_CSR_WDATA : 32'h0;
      ST_T_WR_MEPC:   CSR_WDATA = pc_r;
      ST_T_WR_MCAUSE: CSR_WDATA = cause_r;
      ST_T_WR_MTVAL:  CSR_WDATA = tval_r;
      ST_T_WR_MST:    CSR_WDATA = trap_mstatus(CSR_RDATA, cap_bit_r, TRAP_MPP);
      ST_M_WR_MST:    CSR_WDATA = mret_mstatus(CSR_RDATA, cap_bit_r);
      default:        CSR_WDATA = 32'h0;
    endcase
  end

  // Sequencer state, trap latches and the registered redirect.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r          <= ST_IDLE;
      cause_r          <= 32'h0;
      pc_r             <= 32'h0;
      tval_r           <= 32'h0;
      cap_bit_r        <= 1'b0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'h0;
    end else begin
      state_r          <= next_state_s;
      redirect_valid_r <= (next_state_s == ST_REDIRECT);
      if (trap_grant_s) begin
        cause_r <= TRAP_CAUSE;
        pc_r    <= {TRAP_PC[31:2], 2'b00};
        tval_r  <= TRAP_TVAL;
      end
      case (state_r)
        ST_T_RD_MST:  cap_bit_r     <= CSR_RDATA[MST_MIE];
        ST_M_RD_MST:  cap_bit_r     <= CSR_RDATA[MST_MPIE];
        ST_T_RD_TVEC: redirect_pc_r <= tvec_target_s;
        ST_M_RD_MEPC: redirect_pc_r <= {CSR_RDATA[31:2], 2'b00};
        default:      cap_bit_r     <= cap_bit_r;
      endcase
    end
  end

endmodule

// File: tb/tb_core_csr_trap_ctrl.sv
// Scoreboard bench: drivers push expected CSR writes, instruction acks and
// redirects; a negedge monitor pops and compares as the DUT presents them.
module tb_core_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0, inst_we = 1'b0, trap_req = 1'b0, mret_req = 1'b0;
  logic [11:0] inst_addr = 12'h0;
  logic [31:0] inst_wdata = 32'h0, trap_cause = 32'h0, trap_pc = 32'h0, trap_tval = 32'h0;
  logic        inst_ack, trap_ack, redirect_valid, busy, csr_we;
  logic [31:0] inst_rdata, redirect_pc, csr_wdata, csr_rdata;
  logic [11:0] csr_addr;
  // Second instance with vectoring disabled; its writes are identical and ignored.
  logic        d2_inst_ack, d2_trap_ack, d2_redirect_valid, d2_busy, d2_csr_we;
  logic [31:0] d2_inst_rdata, d2_redirect_pc, d2_csr_wdata, d2_csr_rdata;
  logic [11:0] d2_csr_addr;

  logic [31:0] mem [4096] = '{default: 32'h0};

  typedef struct { logic [11:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] pc; logic [31:0] pc2; int lat; } rd_t;
  wr_t wr_q[$];
  wr_t ack_q[$];
  rd_t rd_q[$];
  int  total = 0, bad = 0, cyc = 0, ack_cyc = 0;

  always #5 clk = ~clk;

  core_csr_trap_ctrl #(.TVEC_VECTORED_EN(1'b1), .TRAP_MPP(2'b11)) dut (
    .CLK(clk), .RST(rst),
    .INST_CSR_REQ(inst_req), .INST_CSR_ADDR(inst_addr), .INST_CSR_WE(inst_we),
    .INST_CSR_WDATA(inst_wdata), .INST_CSR_ACK(inst_ack), .INST_CSR_RDATA(inst_rdata),
    .TRAP_REQ(trap_req), .TRAP_CAUSE(trap_cause), .TRAP_PC(trap_pc), .TRAP_TVAL(trap_tval),
    .MRET_REQ(mret_req), .TRAP_ACK(trap_ack), .REDIRECT_VALID(redirect_valid),
    .REDIRECT_PC(redirect_pc), .BUSY(busy), .CSR_ADDR(csr_addr), .CSR_WDATA(csr_wdata),
    .CSR_WE(csr_we), .CSR_RDATA(csr_rdata)
  );

  core_csr_trap_ctrl #(.TVEC_VECTORED_EN(1'b0), .TRAP_MPP(2'b11)) dut2 (
    .CLK(clk), .RST(rst),
    .INST_CSR_REQ(inst_req), .INST_CSR_ADDR(inst_addr), .INST_CSR_WE(inst_we),
    .INST_CSR_WDATA(inst_wdata), .INST_CSR_ACK(d2_inst_ack), .INST_CSR_RDATA(d2_inst_rdata),
    .TRAP_REQ(trap_req), .TRAP_CAUSE(trap_cause), .TRAP_PC(trap_pc), .TRAP_TVAL(trap_tval),
    .MRET_REQ(mret_req), .TRAP_ACK(d2_trap_ack), .REDIRECT_VALID(d2_redirect_valid),
    .REDIRECT_PC(d2_redirect_pc), .BUSY(d2_busy), .CSR_ADDR(d2_csr_addr), .CSR_WDATA(d2_csr_wdata),
    .CSR_WE(d2_csr_we), .CSR_RDATA(d2_csr_rdata)
  );

  // CSR file model: combinational read, misa (0x301) is a fixed constant.
  always_comb begin
    csr_rdata    = (csr_addr == 12'h301) ? 32'h4000_1100 : mem[csr_addr];
    d2_csr_rdata = (d2_csr_addr == 12'h301) ? 32'h4000_1100 : mem[d2_csr_addr];
  end

  always @(posedge clk) begin
    if (csr_we) mem[csr_addr] <= csr_wdata;
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [31:0] d);
    wr_t e; e.addr = a; e.data = d; wr_q.push_back(e);
  endtask

  task automatic push_ack(input logic [11:0] a, input logic [31:0] d);
    wr_t e; e.addr = a; e.data = d; ack_q.push_back(e);
  endtask

  task automatic push_rd(input logic [31:0] pc, input logic [31:0] pc2, input int lat);
    rd_t e; e.pc = pc; e.pc2 = pc2; e.lat = lat; rd_q.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    wr_t w;
    rd_t r;
    if (trap_ack) ack_cyc = cyc;
    if (inst_ack) begin
      if (ack_q.size() == 0) miss("unexpected_inst_ack");
      else begin
        w = ack_q.pop_front();
        chk("inst_addr", {20'h0, csr_addr}, {20'h0, w.addr});
        chk("inst_rdata", inst_rdata, w.data);
      end
    end
    if (csr_we) begin
      if (wr_q.size() == 0) miss("unexpected_csr_write");
      else begin
        w = wr_q.pop_front();
        chk("wr_addr", {20'h0, csr_addr}, {20'h0, w.addr});
        chk("wr_data", csr_wdata, w.data);
      end
    end
    if (redirect_valid) begin
      if (rd_q.size() == 0) miss("unexpected_redirect");
      else begin
        r = rd_q.pop_front();
        chk("redirect_pc", redirect_pc, r.pc);
        chk("redirect_lat", 32'(cyc - ack_cyc), 32'(r.lat));
        chk("direct_valid", {31'h0, d2_redirect_valid}, 32'h1);
        chk("direct_pc", d2_redirect_pc, r.pc2);
      end
    end
  end

  task automatic do_inst(input logic [11:0] a, input logic we, input logic [31:0] wd, output int waits);
    inst_req = 1'b1; inst_addr = a; inst_we = we; inst_wdata = wd; waits = 0;
    @(negedge clk);
    while (!inst_ack && waits < 60) begin waits++; @(negedge clk); end
    if (!inst_ack) miss("inst_ack_timeout");
    @(posedge clk); #1;
    inst_req = 1'b0; inst_we = 1'b0;
  endtask

  task automatic do_trap(input logic [31:0] c, input logic [31:0] pc, input logic [31:0] tv);
    int n = 0;
    trap_req = 1'b1; trap_cause = c; trap_pc = pc; trap_tval = tv;
    @(negedge clk);
    while (!trap_ack && n < 60) begin n++; @(negedge clk); end
    if (!trap_ack) miss("trap_ack_timeout");
    @(posedge clk); #1;
    trap_req = 1'b0;
  endtask

  task automatic do_mret();
    int n = 0;
    mret_req = 1'b1;
    @(negedge clk);
    while (!(trap_ack && !trap_req) && n < 60) begin n++; @(negedge clk); end
    if (!(trap_ack && !trap_req)) miss("mret_ack_timeout");
    @(posedge clk); #1;
    mret_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rd_q.size() != 0 || busy) && n < 60) begin n++; @(posedge clk); #1; end
    if (rd_q.size() != 0 || busy) miss("drain_timeout");
  endtask

  initial begin
    int w, w5;
    // 1: reset with a pending request, then a same-cycle instruction read
    inst_req = 1'b1; inst_addr = 12'h301;
    #12;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_trap_ack", {31'h0, trap_ack}, 32'h0);
    chk("rst_inst_ack", {31'h0, inst_ack}, 32'h0);
    chk("rst_redirect_valid", {31'h0, redirect_valid}, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_csr_we", {31'h0, csr_we}, 32'h0);
    chk("rst_csr_addr", {20'h0, csr_addr}, 32'h0);
    chk("rst_csr_wdata", csr_wdata, 32'h0);
    inst_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    push_ack(12'h301, 32'h4000_1100);
    do_inst(12'h301, 1'b0, 32'h0, w);
    chk("inst_same_cycle_waits", 32'(w), 32'h0);

    // setup mtvec=0x1000, mstatus.MIE=1 through the instruction path
    push_ack(12'h305, 32'h0); push_wr(12'h305, 32'h0000_1000);
    do_inst(12'h305, 1'b1, 32'h0000_1000, w);
    push_ack(12'h300, 32'h0); push_wr(12'h300, 32'h0000_0008);
    do_inst(12'h300, 1'b1, 32'h0000_0008, w);

    // 2: direct-mode trap
    push_wr(12'h341, 32'h80); push_wr(12'h342, 32'h2); push_wr(12'h343, 32'hDEAD);
    push_wr(12'h300, 32'h1880); push_rd(32'h1000, 32'h1000, 7);
    do_trap(32'h2, 32'h80, 32'hDEAD);
    drain();

    // 3: vectored interrupt; PC low bits dropped
    push_ack(12'h305, 32'h1000); push_wr(12'h305, 32'h1001);
    do_inst(12'h305, 1'b1, 32'h1001, w);
    push_wr(12'h341, 32'h100); push_wr(12'h342, 32'h8000_0007); push_wr(12'h343, 32'h0);
    push_wr(12'h300, 32'h1800); push_rd(32'h101C, 32'h1000, 7);
    do_trap(32'h8000_0007, 32'h103, 32'h0);
    drain();

    // 3b: vectored target wraps past 2^32
    push_ack(12'h305, 32'h1001); push_wr(12'h305, 32'hFFFF_FFC1);
    do_inst(12'h305, 1'b1, 32'hFFFF_FFC1, w);
    push_wr(12'h341, 32'h300); push_wr(12'h342, 32'h8000_001F); push_wr(12'h343, 32'h5);
    push_wr(12'h300, 32'h1800); push_rd(32'h0000_003C, 32'hFFFF_FFC0, 7);
    do_trap(32'h8000_001F, 32'h300, 32'h5);
    drain();

    // 4: MRET
    push_ack(12'h300, 32'h1800); push_wr(12'h300, 32'h1880);
    do_inst(12'h300, 1'b1, 32'h1880, w);
    push_ack(12'h341, 32'h300); push_wr(12'h341, 32'h84);
    do_inst(12'h341, 1'b1, 32'h84, w);
    push_wr(12'h300, 32'h0088); push_rd(32'h84, 32'h84, 4);
    do_mret();
    drain();

    // 5: all three requests together; mtvec mode 2'b10 acts as direct
    push_ack(12'h305, 32'hFFFF_FFC1); push_wr(12'h305, 32'h1006);
    do_inst(12'h305, 1'b1, 32'h1006, w);
    push_wr(12'h341, 32'h200); push_wr(12'h342, 32'h8000_0003); push_wr(12'h343, 32'h11);
    push_wr(12'h300, 32'h1880); push_rd(32'h1004, 32'h1004, 7);
    push_wr(12'h300, 32'h0088); push_rd(32'h200, 32'h200, 4);
    push_ack(12'h340, 32'h0); push_wr(12'h340, 32'h55);
    fork
      do_trap(32'h8000_0003, 32'h200, 32'h11);
      do_mret();
      do_inst(12'h340, 1'b1, 32'h55, w5);
    join
    chk("inst_stall_waits", 32'(w5), 32'd13);
    drain();

    // 6: reset while in WR_MCAUSE
    push_wr(12'h341, 32'h400);
    trap_req = 1'b1; trap_cause = 32'h5; trap_pc = 32'h400; trap_tval = 32'h0;
    w = 0;
    @(negedge clk);
    while (!trap_ack && w < 60) begin w++; @(negedge clk); end
    if (!trap_ack) miss("trap6_ack_timeout");
    @(posedge clk); #1 trap_req = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_csr_we", {31'h0, csr_we}, 32'h0);
    chk("abort_redirect_valid", {31'h0, redirect_valid}, 32'h0);
    chk("abort_redirect_pc", redirect_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_mepc_kept", mem[12'h341], 32'h400);
    chk("abort_mcause_untouched", mem[12'h342], 32'h8000_0003);
    chk("idle_after_abort", {31'h0, busy}, 32'h0);

    chk("wr_q_empty", 32'(wr_q.size()), 32'h0);
    chk("ack_q_empty", 32'(ack_q.size()), 32'h0);
    chk("rd_q_empty", 32'(rd_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
